pipe_ctrl_apply: RTL
====================

PIPE_CTRL_APPLY -- requirements
Module: pipe_ctrl_apply

Interface
REQ-001 Parameter THRESHOLD_WIDTH, default 26, SHALL set the width of the Sobel threshold path.
REQ-002 Parameter FLUSH_CYCLES, default 4, range 1..255, SHALL set the buffer-clear pulse length in clocks.
REQ-003 i_sysclk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 i_rstn  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 i_sof  in  1  SHALL be the one-cycle start-of-frame strobe from the video pipeline.
REQ-006 i_mode  in  1  SHALL be the requested mode: 0 = passthrough, 1 = filtered.
REQ-007 i_gaussian_enable, i_sobel_enable  in  1 each  SHALL be the requested filter enables.
REQ-008 i_sobel_threshold  in  THRESHOLD_WIDTH  SHALL be the requested Sobel threshold.
REQ-009 i_pipe_flush  in  1  SHALL be the flush request, a level held until a frame boundary.
REQ-010 o_bypass, o_gaussian_en, o_sobel_en  out  1 each  SHALL be the frame-committed controls.
REQ-011 o_threshold  out  THRESHOLD_WIDTH  SHALL be the frame-committed threshold.
REQ-012 o_buf_clear  out  1  SHALL clear the line buffers.
REQ-013 o_video_mute  out  1  SHALL blank pixel output.
REQ-014 o_flush_busy  out  1  SHALL indicate a flush in progress.
REQ-015 o_flush_done  out  1  SHALL be a one-cycle strobe marking flush completion.
REQ-016 o_frame_cnt  out  16  SHALL be the committed-frame count.

Function
REQ-017 Requested inputs SHALL be registered every cycle into pending registers.
REQ-018 On a cycle with i_sof=1, pending values SHALL commit to the outputs, visible on the next cycle; outputs SHALL NOT change at any other time.
REQ-019 The commit SHALL force o_bypass=1, o_gaussian_en=0 and o_sobel_en=0 when pending mode=0, and o_bypass=0 with the pending enables when mode=1.
REQ-020 o_threshold SHALL commit unchanged in both modes.
REQ-021 Flush FSM states SHALL be IDLE, ARMED, CLEAR and DRAIN.
REQ-022 IDLE SHALL go to ARMED on a rising edge of i_pipe_flush; an i_sof in that same cycle SHALL NOT advance the FSM.
REQ-023 ARMED SHALL go to CLEAR on i_sof.
REQ-024 CLEAR SHALL hold o_buf_clear=1 for exactly FLUSH_CYCLES cycles, then go to DRAIN.
REQ-025 DRAIN SHALL hold o_video_mute=1 until the next i_sof, then pulse o_flush_done for one cycle and leave.
REQ-026 o_flush_busy SHALL be 1 in ARMED, CLEAR and DRAIN.
REQ-027 o_video_mute SHALL also be 1 in CLEAR.
REQ-028 A rising edge of i_pipe_flush during CLEAR or DRAIN SHALL set a sticky re-arm flag; on leaving DRAIN, the FSM SHALL go to ARMED if the flag is set (clearing it), else to IDLE.
REQ-029 The o_flush_done strobe SHALL be issued in both cases of REQ-028.
REQ-030 i_sof arriving during CLEAR SHALL still commit controls but SHALL NOT shorten CLEAR.
REQ-031 A flush request deasserted while ARMED SHALL NOT cancel the flush.
REQ-032 The i_pipe_flush rising-edge detector SHALL use a registered copy of the input.

Reset
REQ-033 Asserting i_rstn low SHALL immediately set the following reset values, including mid-flush:
- o_bypass=1; o_gaussian_en=0; o_sobel_en=0.
- o_threshold=4000.
- o_buf_clear=0; o_video_mute=0; o_flush_busy=0; o_flush_done=0.
- o_frame_cnt=0; FSM=IDLE.
- re-arm flag, pending registers and edge register cleared, with pending mode=0.
REQ-034 The first commit after reset release SHALL occur only at the first i_sof.

Configuration
REQ-035 With macro PIPE_CTRL_FRAMECNT_EN defined, o_frame_cnt SHALL increment on every i_sof, wrap from 0xFFFF to 0x0000, and clear to 0 on o_flush_done.
REQ-036 Without PIPE_CTRL_FRAMECNT_EN, the port SHALL remain and be tied to 0, and no counter SHALL be synthesised.

Structure
REQ-037 Package pipe_ctrl_pkg SHALL hold the flush-state encoding, the THRESHOLD_WIDTH default, the reset threshold value 4000 and the FLUSH_CYCLES default.
REQ-038 Sub-module pipe_flush_fsm SHALL contain the flush FSM, the clear counter and the re-arm flag; commit logic and the frame counter SHALL stay in the top level.

Verification
REQ-039 Mode=1, gaussian=1, threshold=4500, no sof for 100 cycles, then sof -> outputs unchanged until the cycle after sof, then o_bypass=0, o_gaussian_en=1, o_threshold=4500.
REQ-040 Mode=0 with both enables=1, then sof -> o_bypass=1, o_gaussian_en=0, o_sobel_en=0.
REQ-041 Flush rise at cycle 10, sof at 50 and 200, FLUSH_CYCLES=4 -> o_buf_clear high cycles 51-54, mute 51-200, o_flush_done at 201, busy 11-200.
REQ-042 Second flush rise during DRAIN -> after the done strobe, FSM re-enters ARMED and a second CLEAR starts on the following sof.
REQ-043 Reset asserted during CLEAR -> all outputs take their reset values without waiting for a clock edge; after release, no clear until a new request plus sof.
REQ-044 With PIPE_CTRL_FRAMECNT_EN, counter preset to 0xFFFF, then sof -> 0x0000; without the macro, o_frame_cnt stays 0 throughout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the frame-synchronous pipeline control block.
// Holds the flush-state encoding, threshold width/reset value and clear-pulse default.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_ARMED = 2'd1,
        FL_CLEAR = 2'd2,
        FL_DRAIN = 2'd3
    } flush_state_e;

    localparam int THRESHOLD_WIDTH_DEF = 26;
    localparam int RST_THRESHOLD       = 4000;
    localparam int FLUSH_CYCLES_DEF    = 4;

endpackage

// File: rtl/pipe_flush_fsm.sv
// Flush sequencer: arm on request edge, clear buffers for FLUSH_CYCLES, mute until next SOF.
// Outputs are Moore on state; done is a registered one-cycle strobe. No backpressure.
module pipe_flush_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic i_sysclk,
    input  logic i_rstn,
    input  logic i_sof,
    input  logic i_pipe_flush,
    output logic o_buf_clear,
    output logic o_video_mute,
    output logic o_flush_busy,
    output logic o_flush_done
);

    flush_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         rearm_q, rearm_d;
    logic         done_q, done_d;
    logic         flush_q;
    logic         flush_rise;

    assign flush_rise = i_pipe_flush & ~flush_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rearm_d = rearm_q;
        done_d  = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (flush_rise) state_d = FL_ARMED;
            end
            FL_ARMED: begin
                if (i_sof) begin
                    state_d = FL_CLEAR;
                    cnt_d   = 8'(FLUSH_CYCLES - 1);
                end
            end
            FL_CLEAR: begin
                if (flush_rise) rearm_d = 1'b1;
                if (cnt_q == 8'd0) state_d = FL_DRAIN;
                else               cnt_d   = cnt_q - 8'd1;
            end
            FL_DRAIN: begin
                if (flush_rise) rearm_d = 1'b1;
                if (i_sof) begin
                    done_d = 1'b1;
                    // A request arriving on the very exit cycle still re-arms.
                    if (rearm_q || flush_rise) begin
                        state_d = FL_ARMED;
                        rearm_d = 1'b0;
                    end else begin
                        state_d = FL_IDLE;
                    end
                end
            end
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= FL_IDLE;
            cnt_q   <= 8'd0;
            rearm_q <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rearm_q <= rearm_d;
            done_q  <= done_d;
            flush_q <= i_pipe_flush;
        end
    end

    assign o_buf_clear  = (state_q == FL_CLEAR);
    assign o_video_mute = (state_q == FL_CLEAR) || (state_q == FL_DRAIN);
    assign o_flush_busy = (state_q != FL_IDLE);
    assign o_flush_done = done_q;

endmodule

// File: rtl/pipe_ctrl_apply.sv
// Frame-synchronous control apply: requests are staged every cycle and committed on SOF (1-cycle latency).
// No backpressure. Optional frame counter under macro PIPE_CTRL_FRAMECNT_EN.
module pipe_ctrl_apply
    import pipe_ctrl_pkg::*;
#(
    parameter int THRESHOLD_WIDTH = THRESHOLD_WIDTH_DEF,
    parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF
) (
    input  logic                       i_sysclk,
    input  logic                       i_rstn,
    input  logic                       i_sof,
    input  logic                       i_mode,
    input  logic                       i_gaussian_enable,
    input  logic                       i_sobel_enable,
    input  logic [THRESHOLD_WIDTH-1:0] i_sobel_threshold,
    input  logic                       i_pipe_flush,
    output logic                       o_bypass,
    output logic                       o_gaussian_en,
    output logic                       o_sobel_en,
    output logic [THRESHOLD_WIDTH-1:0] o_threshold,
    output logic                       o_buf_clear,
    output logic                       o_video_mute,
    output logic                       o_flush_busy,
    output logic                       o_flush_done,
    output logic [15:0]                o_frame_cnt
);

    logic                       pend_mode_q, pend_gauss_q, pend_sobel_q;
    logic [THRESHOLD_WIDTH-1:0] pend_thr_q;

    logic                       bypass_q, bypass_d;
    logic                       gauss_q, gauss_d;
    logic                       sobel_q, sobel_d;
    logic [THRESHOLD_WIDTH-1:0] thr_q, thr_d;

    always_comb begin
        bypass_d = bypass_q;
        gauss_d  = gauss_q;
        sobel_d  = sobel_q;
        thr_d    = thr_q;
        if (i_sof) begin
            // Passthrough forces both filters off regardless of requested enables.
            bypass_d = ~pend_mode_q;
            gauss_d  = pend_mode_q & pend_gauss_q;
            sobel_d  = pend_mode_q & pend_sobel_q;
            thr_d    = pend_thr_q;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) begin
            pend_mode_q  <= 1'b0;
            pend_gauss_q <= 1'b0;
            pend_sobel_q <= 1'b0;
            pend_thr_q   <= '0;
            bypass_q     <= 1'b1;
            gauss_q      <= 1'b0;
            sobel_q      <= 1'b0;
            thr_q        <= THRESHOLD_WIDTH'(RST_THRESHOLD);
        end else begin
            pend_mode_q  <= i_mode;
            pend_gauss_q <= i_gaussian_enable;
            pend_sobel_q <= i_sobel_enable;
            pend_thr_q   <= i_sobel_threshold;
            bypass_q     <= bypass_d;
            gauss_q      <= gauss_d;
            sobel_q      <= sobel_d;
            thr_q        <= thr_d;
        end
    end

    assign o_bypass      = bypass_q;
    assign o_gaussian_en = gauss_q;
    assign o_sobel_en    = sobel_q;
    assign o_threshold   = thr_q;

    pipe_flush_fsm #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_fsm (
        .i_sysclk     (i_sysclk),
        .i_rstn       (i_rstn),
        .i_sof        (i_sof),
        .i_pipe_flush (i_pipe_flush),
        .o_buf_clear  (o_buf_clear),
        .o_video_mute (o_video_mute),
        .o_flush_busy (o_flush_busy),
        .o_flush_done (o_flush_done)
    );

`ifdef PIPE_CTRL_FRAMECNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (o_flush_done) frame_cnt_d = 16'd0;
        else if (i_sof)   frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge i_sysclk or negedge i_rstn) begin
        if (!i_rstn) frame_cnt_q <= 16'd0;
        else         frame_cnt_q <= frame_cnt_d;
    end

    assign o_frame_cnt = frame_cnt_q;
`else
    assign o_frame_cnt = 16'd0;
`endif

endmodule
